// File: rtl/apb_cmd_arbiter.sv
// Round-robin arbiter sharing one APB master command port between N_REQ requesters.
// Latches the winner's command, holds it until completion or watchdog abort, returns status.
module apb_cmd_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_write,
  input  logic [N_REQ*32-1:0] req_addr,
  input  logic [N_REQ*32-1:0] req_wdata,
  output logic [N_REQ-1:0]   req_grant,
  output logic [N_REQ-1:0]   req_done,
  output logic [31:0]        req_rdata,
  output logic               req_slverr,
  output logic               TRANSFER,
  output logic               write,
  output logic               read,
  output logic [31:0]        apb_write_address,
  output logic [31:0]        apb_read_address,
  output logic [31:0]        apb_write_data,
  input  logic               PENABLE,
  input  logic               pready1,
  input  logic               PSLVERR,
  input  logic [31:0]        apb_read_out
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              last_q, last_d, win_q, win_d;
  logic [31:0]                wdog_q, wdog_d;
  logic [N_REQ-1:0][31:0]     addr_v, wdata_v;
  logic                       sel_found;
  logic [IW-1:0]              sel_idx;

  logic                       transfer_d, write_d, read_d, slverr_d;
  logic [31:0]                waddr_d, raddr_d, wdata_d, rdata_d;
  logic [N_REQ-1:0]           grant_d, done_d;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_v[g]  = req_addr[32*g +: 32];
    assign wdata_v[g] = req_wdata[32*g +: 32];
  end

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!sel_found && req_valid[(int'(last_q) + i) % N_REQ]) begin
        sel_found = 1'b1;
        sel_idx   = IW'((int'(last_q) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    wdog_d     = wdog_q;
    transfer_d = TRANSFER;
    write_d    = write;
    read_d     = read;
    waddr_d    = apb_write_address;
    raddr_d    = apb_read_address;
    wdata_d    = apb_write_data;
    grant_d    = req_grant;
    done_d     = '0;
    rdata_d    = req_rdata;
    slverr_d   = req_slverr;
    case (state_q)
      IDLE: if (sel_found) begin
        state_d          = BUSY;
        win_d            = sel_idx;
        wdog_d           = '0;
        transfer_d       = 1'b1;
        write_d          = req_write[sel_idx];
        read_d           = !req_write[sel_idx];
        waddr_d          = addr_v[sel_idx];
        raddr_d          = addr_v[sel_idx];
        wdata_d          = req_write[sel_idx] ? wdata_v[sel_idx] : 32'h0;
        grant_d          = '0;
        grant_d[sel_idx] = 1'b1;
      end
      BUSY: begin
        // Completion is checked first so it wins over a same-cycle timeout.
        if (PENABLE && pready1) begin
          state_d    = DONE;
          transfer_d = 1'b0;
          write_d    = 1'b0;
          read_d     = 1'b0;
          done_d     = req_grant;
          rdata_d    = write ? 32'h0 : apb_read_out;
          slverr_d   = PSLVERR;
        end else if (TIMEOUT != 0 && (wdog_q + 32'd1) == 32'(TIMEOUT)) begin
          state_d    = DONE;
          transfer_d = 1'b0;
          write_d    = 1'b0;
          read_d     = 1'b0;
          done_d     = req_grant;
          rdata_d    = 32'h0;
          slverr_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        last_d  = win_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q           <= IDLE;
      last_q            <= IW'(N_REQ - 1);
      win_q             <= '0;
      wdog_q            <= '0;
      TRANSFER          <= 1'b0;
      write             <= 1'b0;
      read              <= 1'b0;
      apb_write_address <= '0;
      apb_read_address  <= '0;
      apb_write_data    <= '0;
      req_grant         <= '0;
      req_done          <= '0;
      req_rdata         <= '0;
      req_slverr        <= 1'b0;
    end else begin
      state_q           <= state_d;
      last_q            <= last_d;
      win_q             <= win_d;
      wdog_q            <= wdog_d;
      TRANSFER          <= transfer_d;
      write             <= write_d;
      read              <= read_d;
      apb_write_address <= waddr_d;
      apb_read_address  <= raddr_d;
      apb_write_data    <= wdata_d;
      req_grant         <= grant_d;
      req_done          <= done_d;
      req_rdata         <= rdata_d;
      req_slverr        <= slverr_d;
    end
  end
endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Directed bench for apb_cmd_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares on every req_done pulse.
module tb_apb_cmd_arbiter;
  localparam int N = 2;

  logic          PCLK, PRESETn;
  logic [N-1:0]  req_valid, req_write;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [N-1:0]  req_grant, req_done;
  logic [31:0]   req_rdata;
  logic          req_slverr;
  logic          TRANSFER, write, read;
  logic [31:0]   apb_write_address, apb_read_address, apb_write_data;
  logic          PENABLE, pready1, PSLVERR;
  logic [31:0]   apb_read_out;

  typedef struct {
    logic [N-1:0] done;
    logic [31:0]  rdata;
    logic         slverr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  apb_cmd_arbiter #(.N_REQ(N), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .req_done(req_done),
    .req_rdata(req_rdata), .req_slverr(req_slverr),
    .TRANSFER(TRANSFER), .write(write), .read(read),
    .apb_write_address(apb_write_address), .apb_read_address(apb_read_address),
    .apb_write_data(apb_write_data),
    .PENABLE(PENABLE), .pready1(pready1), .PSLVERR(PSLVERR),
    .apb_read_out(apb_read_out)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every req_done pulse must match the oldest expectation.
  always @(negedge PCLK) begin
    if (PRESETn && req_done !== '0) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 32'(req_done), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_vec", 32'(req_done), 32'(mon_e.done));
        chk("rdata", req_rdata, mon_e.rdata);
        chk("slverr", 32'(req_slverr), 32'(mon_e.slverr));
      end
    end
  end

  task automatic set_req(input int idx, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    req_write[idx]          = wr;
    req_addr[32*idx +: 32]  = addr;
    req_wdata[32*idx +: 32] = wd;
  endtask

  // Expect requester idx to be granted next; waits < 0 means the slave never responds.
  task automatic serve(input int idx, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input int waits, input logic [31:0] rd, input bit err,
                       input logic [31:0] exp_rd, input bit exp_err, input int exp_cycles);
    exp_t e;
    logic [N-1:0] oh;
    bit got;
    int cnt;
    oh = '0;
    oh[idx] = 1'b1;
    e.done = oh; e.rdata = exp_rd; e.slverr = exp_err;
    exp_q.push_back(e);
    got = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge PCLK); #1;
      if (TRANSFER) begin got = 1; break; end
    end
    if (!got) begin
      chk("transfer_start_timeout", 32'h0, 32'h1);
      return;
    end
    chk("grant", 32'(req_grant), 32'(oh));
    chk("write", 32'(write), 32'(wr));
    chk("read", 32'(read), 32'(!wr));
    chk("waddr", apb_write_address, addr);
    chk("raddr", apb_read_address, addr);
    chk("wdata", apb_write_data, wr ? wd : 32'h0);
    cnt = 1;
    if (waits < 0) begin
      for (int n = 0; n < 40; n++) begin
        @(posedge PCLK); #1;
        if (!TRANSFER) break;
        cnt++;
      end
    end else begin
      for (int n = 0; n < waits; n++) begin
        @(posedge PCLK); #1;
        if (TRANSFER) cnt++;
      end
      PENABLE = 1'b1; pready1 = 1'b1; PSLVERR = err; apb_read_out = rd;
      @(posedge PCLK); #1;
      PENABLE = 1'b0; pready1 = 1'b0; PSLVERR = 1'b0; apb_read_out = 32'h0;
    end
    chk("transfer_cycles", 32'(cnt), 32'(exp_cycles));
    chk("transfer_done_low", 32'({TRANSFER, write, read}), 32'h0);
    chk("grant_in_done", 32'(req_grant), 32'(oh));
  endtask

  initial begin
    bit got;
    PRESETn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PENABLE = 1'b0; pready1 = 1'b0; PSLVERR = 1'b0; apb_read_out = 32'h0;
    #3;
    chk("rst_ctrl", 32'({TRANSFER, write, read, req_grant, req_done, req_slverr}), 32'h0);
    chk("rst_data", apb_write_address | apb_read_address | apb_write_data | req_rdata, 32'h0);
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // Single write, slave ready after 2 wait cycles
    set_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    req_valid = 2'b01;
    serve(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2, 32'h5555_5555, 1'b0, 32'h0, 1'b0, 3);
    req_valid = '0;

    // Read with slave error
    set_req(1, 1'b0, 32'h0000_0020, 32'hFFFF_FFFF);
    req_valid = 2'b10;
    serve(1, 1'b0, 32'h20, 32'h0, 0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1);
    req_valid = '0;

    // Fairness: both held valid across four accesses
    set_req(0, 1'b1, 32'h100, 32'h0000_00A0);
    set_req(1, 1'b0, 32'h104, 32'h0);
    req_valid = 2'b11;
    serve(0, 1'b1, 32'h100, 32'hA0, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1);
    serve(1, 1'b0, 32'h104, 32'h0, 1, 32'h0000_1111, 1'b0, 32'h0000_1111, 1'b0, 2);
    serve(0, 1'b1, 32'h100, 32'hA0, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1);
    serve(1, 1'b0, 32'h104, 32'h0, 0, 32'h0000_2222, 1'b0, 32'h0000_2222, 1'b0, 1);
    req_valid = '0;

    // Watchdog abort: slave never ready
    set_req(0, 1'b0, 32'h30, 32'h0);
    req_valid = 2'b01;
    serve(0, 1'b0, 32'h30, 32'h0, -1, 32'h0, 1'b0, 32'h0, 1'b1, 16);
    req_valid = '0;

    // Next access after abort proceeds normally
    set_req(1, 1'b1, 32'h40, 32'h0BAD_F00D);
    req_valid = 2'b10;
    serve(1, 1'b1, 32'h40, 32'h0BAD_F00D, 1, 32'h0, 1'b0, 32'h0, 1'b0, 2);
    req_valid = '0;

    // Completion on the same cycle the watchdog expires
    set_req(0, 1'b0, 32'h50, 32'h0);
    req_valid = 2'b01;
    serve(0, 1'b0, 32'h50, 32'h0, 15, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 16);
    req_valid = '0;

    // Reset in the middle of an access
    set_req(1, 1'b1, 32'h60, 32'h1);
    req_valid = 2'b10;
    got = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge PCLK); #1;
      if (TRANSFER) begin got = 1; break; end
    end
    chk("midrst_transfer_up", 32'(got), 32'h1);
    @(posedge PCLK); #2;
    PRESETn = 1'b0;
    #1;
    chk("midrst_ctrl", 32'({TRANSFER, write, read, req_grant, req_done}), 32'h0);
    chk("midrst_addr", apb_write_address | apb_write_data, 32'h0);
    set_req(0, 1'b1, 32'h70, 32'h7777_7777);
    req_valid = 2'b11;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    serve(0, 1'b1, 32'h70, 32'h7777_7777, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1);
    req_valid[0] = 1'b0;
    serve(1, 1'b1, 32'h60, 32'h1, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1);
    req_valid = '0;

    repeat (5) @(posedge PCLK);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_cmd_arbiter.md
# apb_cmd_arbiter

Round-robin arbiter that shares the single APB master command port (TRANSFER/write/read/address/data) between N_REQ internal requesters. It latches one requester's command, holds it on the master port until the APB access completes (PENABLE && pready1), then returns read data and error status to that requester. A watchdog aborts accesses that never complete. It sits directly in front of the APB master bridge, on the PCLK domain.

## Interface
- N_REQ, default 2: number of requesters, 2..8.
- TIMEOUT, default 16: max BUSY cycles before abort; 0 disables the watchdog.
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester command request.
- req_write  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*32  per-requester address, requester i at bits [32i+31:32i].
- req_wdata  in  N_REQ*32  per-requester write data, same packing.
- req_grant  out  N_REQ  one-hot, high while requester's command is owned (BUSY and DONE).
- req_done  out  N_REQ  one-hot, one-cycle completion pulse.
- req_rdata  out  32  read data of completed access; valid with req_done.
- req_slverr  out  1  error of completed access; valid with req_done.
- TRANSFER  out  1  command strobe to APB master.
- write, read  out  1 each  command type to APB master; mutually exclusive.
- apb_write_address, apb_read_address  out  32 each  latched address.
- apb_write_data  out  32  latched write data; 0 for reads.
- PENABLE, pready1, PSLVERR  in  1 each  APB access phase status.
- apb_read_out  in  32  APB read data.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any req_valid, select winner by round-robin starting at last_grant+1 modulo N_REQ; latch req_write/addr/wdata of winner; set grant; -> BUSY. Otherwise stay.
- BUSY: TRANSFER=1; write=latched req_write, read=!latched req_write; both addresses = latched address. Watchdog counts BUSY cycles. When PENABLE && pready1 sampled high: capture apb_read_out (reads; 0 for writes) and PSLVERR -> DONE. When TIMEOUT != 0 and count reaches TIMEOUT without completion: rdata=0, slverr=1 -> DONE.
- DONE: TRANSFER=0, write=read=0; req_done[winner]=1 for one cycle; last_grant <= winner; -> IDLE.
- Completion and timeout in the same cycle: completion wins (slverr = PSLVERR).
- Requester contract: hold req_valid and fields stable until grant; after grant the command is latched and input changes are ignored. req_valid still high in the DONE cycle counts as a new request in the following IDLE.
- Withdrawing req_valid before grant is legal; no grant issued.
- Inputs PENABLE/pready1 outside BUSY are ignored.

## Timing
- Reset (asynchronous, immediate): state IDLE, last_grant = N_REQ-1, watchdog 0; all outputs 0 (TRANSFER, write, read, addresses, wdata, req_grant, req_done, req_rdata, req_slverr). Reset mid-BUSY drops TRANSFER at once; no req_done is issued for the aborted command.
- All outputs registered.
- req_valid sampled in IDLE at edge k -> req_grant and TRANSFER high from cycle k+1.
- Completion sampled at edge m -> TRANSFER low, req_done/rdata/slverr valid in cycle m+1 (DONE); IDLE at m+2; next TRANSFER no earlier than m+3.
- req_rdata/req_slverr hold their value until the next DONE.
- Timeout: TRANSFER high exactly TIMEOUT cycles, then DONE.
- Minimum per-access occupancy: 1 BUSY + 1 DONE + 1 IDLE = 3 cycles plus APB wait.

## Test plan
- Reset: PRESETn low mid-BUSY -> TRANSFER, grant, req_done all 0 immediately; after release first request from requester 0 wins.
- Single write: req 0 write addr 0x0000_0010 data 0xDEAD_BEEF, pready1 after 2 cycles -> TRANSFER high 1 cycle after request, apb_write_address 0x10, apb_write_data 0xDEADBEEF, req_done[0] one pulse, req_slverr 0.
- Read: req 1 read addr 0x20, apb_read_out 0x1234_5678, PSLVERR 1 at completion -> req_rdata 0x12345678, req_slverr 1, req_done[1] pulse.
- Fairness: both requesters hold valid for 4 accesses -> grant order 0,1,0,1; no requester starved.
- Timeout: TIMEOUT=16, pready1 never high -> TRANSFER high 16 cycles, req_done pulse with req_slverr 1, req_rdata 0; next request served normally.
- Simultaneous completion and timeout at cycle 16 with PSLVERR 0 -> req_slverr 0, rdata from apb_read_out.
